// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
// Holds the controller state encoding and the default operand width.
package serial_adder_pkg;

  localparam int WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : serial_adder_pkg

// File: rtl/serial_adder_full_adder_cell.sv
// Single-bit full adder, the only arithmetic element of the serial adder.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule : full_adder_cell

// File: rtl/serial_adder.sv
// Bit-serial adder: one bit per clock, LSB first, through one full-adder cell.
// Fixed latency of WIDTH cycles from operand accept to result valid.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             co
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_s;
  logic             fa_co;

  full_adder_cell u_fa (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  // Controller next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (in_valid) state_next = RUN;
        else          state_next = IDLE;
      end
      RUN: begin
        if (cnt == LAST) state_next = DONE;
        else             state_next = RUN;
      end
      DONE: begin
        if (out_ready) state_next = IDLE;
        else           state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Operand shifters, result shifter, carry and bit counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh  <= '0;
      b_sh  <= '0;
      res   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= ci;
            cnt   <= '0;
          end
        end
        RUN: begin
          // Sum bits enter from the MSB so bit 0 lands in place after WIDTH shifts
          res   <= {fa_s, res[WIDTH-1:1]};
          a_sh  <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh  <= {1'b0, b_sh[WIDTH-1:1]};
          carry <= fa_co;
          cnt   <= cnt + CW'(1);
        end
        DONE: begin
          res <= res;
        end
        default: begin
          cnt <= '0;
        end
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign sum       = res;
  assign co        = carry;

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
// Directed and randomized self-checking bench for serial_adder (WIDTH=8).
module tb_serial_adder;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       ci;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] sum;
  logic       co;

  int vectors     = 0;
  int miscompares = 0;

  serial_adder #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .ci        (ci),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .co        (co)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One complete operation; operands are scrambled right after acceptance
  task automatic do_op(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                       input logic tci, input logic [8:0] exp, input bit hold5);
    int w;
    int lat;
    a = ta; b = tb; ci = tci; in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 20) begin tick(); w++; end
    chk({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    a = ~ta; b = tb ^ 8'hA5; ci = ~tci;
    lat = 0;
    while (!out_valid && lat < 40) begin tick(); lat++; end
    chk({tag, "_latency"}, lat, 32'd8);
    chk({tag, "_sum"}, {24'd0, sum}, {24'd0, exp[7:0]});
    chk({tag, "_co"}, {31'd0, co}, {31'd0, exp[8]});
    if (hold5) begin
      for (int i = 0; i < 5; i++) begin
        tick();
        chk({tag, "_hold_valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_hold_inready"}, {31'd0, in_ready}, 32'd0);
        chk({tag, "_hold_sum"}, {24'd0, sum}, {24'd0, exp[7:0]});
        chk({tag, "_hold_co"}, {31'd0, co}, {31'd0, exp[8]});
      end
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_release_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_release_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    logic [8:0] exp;
    logic [8:0] q[$];
    int         lat;
    int         accepted;
    int         received;
    int         cycles;
    bit         acc;
    bit         rel;
    logic [7:0] s_obs;
    logic       c_obs;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = 8'h00; b = 8'h00; ci = 1'b0;
    #1;
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_sum", {24'd0, sum}, 32'd0);
    chk("reset_co", {31'd0, co}, 32'd0);
    tick(); tick();
    rst_n = 1'b1;

    do_op("add_5a_3c", 8'h5A, 8'h3C, 1'b0, 9'h096, 1'b0);
    do_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 9'h100, 1'b0);
    do_op("add_ff_ff_c", 8'hFF, 8'hFF, 1'b1, 9'h1FF, 1'b0);
    do_op("hold_12_34", 8'h12, 8'h34, 1'b1, 9'h047, 1'b1);

    // in_valid pulses during RUN and DONE must be ignored
    a = 8'h10; b = 8'h20; ci = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    a = 8'hAA; b = 8'h55; ci = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("ignore_run_inready", {31'd0, in_ready}, 32'd0);
    lat = 2;
    while (!out_valid && lat < 40) begin tick(); lat++; end
    chk("ignore_latency", lat, 32'd8);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("ignore_done_valid", {31'd0, out_valid}, 32'd1);
    chk("ignore_sum", {24'd0, sum}, 32'h30);
    chk("ignore_co", {31'd0, co}, 32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("ignore_back_idle", {31'd0, in_ready}, 32'd1);

    // Reset in the middle of RUN discards the operation
    a = 8'hC3; b = 8'h5A; ci = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_sum", {24'd0, sum}, 32'd0);
    chk("midrst_co", {31'd0, co}, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    a = 8'h21; b = 8'h43; ci = 1'b1; in_valid = 1'b1;
    rst_n = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("postrst_first_edge_accept", {31'd0, in_ready}, 32'd0);
    lat = 0;
    while (!out_valid && lat < 40) begin tick(); lat++; end
    chk("postrst_latency", lat, 32'd8);
    chk("postrst_sum", {24'd0, sum}, 32'h65);
    chk("postrst_co", {31'd0, co}, 32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Back-to-back random traffic with random consumer stalls
    accepted = 0; received = 0; cycles = 0;
    a = 8'($urandom); b = 8'($urandom); ci = 1'($urandom);
    in_valid = 1'b1;
    out_ready = 1'($urandom);
    while ((accepted < 500 || received < 500) && cycles < 20000) begin
      acc = in_valid && in_ready;
      rel = out_valid && out_ready;
      s_obs = sum;
      c_obs = co;
      if (rel) begin
        if (q.size() == 0) begin
          chk("rand_unexpected_result", 32'd1, 32'd0);
        end else begin
          exp = q.pop_front();
          chk("rand_result", {23'd0, c_obs, s_obs}, {23'd0, exp});
        end
        received++;
      end
      if (acc) begin
        q.push_back({1'b0, a} + {1'b0, b} + {8'd0, ci});
        accepted++;
      end
      tick();
      cycles++;
      if (acc) begin
        a = 8'($urandom); b = 8'($urandom); ci = 1'($urandom);
        if (accepted >= 500) in_valid = 1'b0;
      end
      out_ready = 1'($urandom_range(0, 1));
    end
    chk("rand_accepted", accepted, 32'd500);
    chk("rand_received", received, 32'd500);
    chk("rand_queue_empty", q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_serial_adder

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the operand and sum width in bits (legal range 2..32).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port in_valid, input, 1 bit: the operand set is presented.
REQ-005 SHALL have port in_ready, output, 1 bit: the block can accept operands.
REQ-006 SHALL have port a, input, WIDTH bits: operand A.
REQ-007 SHALL have port b, input, WIDTH bits: operand B.
REQ-008 SHALL have port ci, input, 1 bit: carry-in.
REQ-009 SHALL have port out_valid, output, 1 bit: the result is presented.
REQ-010 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-011 SHALL have port sum, output, WIDTH bits: (a+b+ci) mod 2^WIDTH.
REQ-012 SHALL have port co, output, 1 bit: carry-out of the full addition.

Function
REQ-013 SHALL be a bit-serial adder: one bit position per clock, LSB first, through one 1-bit full-adder cell plus a carry register.
REQ-014 SHALL implement an FSM with three states: IDLE, RUN and DONE.
REQ-015 In IDLE, in_ready SHALL be 1 and out_valid SHALL be 0.
REQ-016 An input handshake is in_valid && in_ready at a rising edge; on it the block SHALL:
- capture a and b into shift registers;
- set carry := ci;
- clear the bit counter;
- go to RUN.
REQ-017 In RUN, each edge SHALL:
- compute the sum bit of the shift-register LSBs and carry;
- shift that sum bit into the result register from the MSB side;
- shift the operand registers right by one;
- update carry;
- increment the counter.
REQ-018 After exactly WIDTH RUN edges, the FSM SHALL enter DONE, with sum holding the full result and co equal to the final carry.
REQ-019 Latency SHALL be fixed: out_valid rises exactly WIDTH cycles after the accepting edge, independent of operand values.
REQ-020 In DONE, out_valid SHALL be 1, in_ready SHALL be 0, and sum/co SHALL stay stable until out_ready is 1.
REQ-021 An output handshake (out_valid && out_ready at an edge) SHALL return the FSM to IDLE; in_ready rises the following cycle, so there is no same-cycle accept.
REQ-022 in_valid asserted during RUN or DONE SHALL be ignored, with no change to state or result.
REQ-023 Changes on a, b or ci after acceptance SHALL NOT affect the result in flight.
REQ-024 The counter SHALL be $clog2(WIDTH+1) bits wide and SHALL NOT wrap within an operation.
REQ-025 Carry overflow SHALL appear only on co; sum SHALL wrap mod 2^WIDTH.
REQ-026 in_ready and out_valid SHALL be driven directly from FSM state, with no combinational path from in_valid or out_ready.

Reset
REQ-027 rst_n=0 SHALL immediately force:
- state IDLE;
- in_ready=1 and out_valid=0;
- sum=0 and co=0;
- carry, counter and shift registers to 0.
REQ-028 Reset asserted mid-RUN or in DONE SHALL discard the operation, with no output handshake produced.
REQ-029 Once rst_n deasserts, the first edge SHALL be able to accept operands.

Structure
REQ-030 A shared package serial_adder_pkg SHALL hold:
- the FSM state enum (IDLE, RUN, DONE);
- the WIDTH default constant.
REQ-031 The 1-bit full-adder SHALL be one sub-module, full_adder_cell (inputs a, b, ci; outputs s, co), instantiated once.
REQ-032 All sub-module connections SHALL use explicitly declared nets; implicit nets are not permitted.

Verification (WIDTH=8)
REQ-033 a=0x5A, b=0x3C, ci=0 -> sum=0x96, co=0, out_valid exactly 8 cycles after accept.
REQ-034 a=0xFF, b=0x01, ci=0 -> sum=0x00, co=1; and a=0xFF, b=0xFF, ci=1 -> sum=0xFF, co=1.
REQ-035 Hold out_ready=0 for 5 cycles in DONE -> out_valid, sum and co stay constant, and in_ready=0 throughout.
REQ-036 Pulse in_valid with different operands during RUN -> ignored, and the first result is unchanged.
REQ-037 rst_n low at RUN cycle 4 -> out_valid=0, sum=0 and in_ready=1 immediately; a new operation afterwards completes correctly.
REQ-038 500 random back-to-back operations with random out_ready -> every result matches a+b+ci, with none lost or duplicated.
